uart_rx_fifo: RTL and testbench

//  Receive-side buffer directly downstream of the simple UART's data register.
//  - Drains each byte the UART holds by pulsing the UART read strobe.
//  - Stores bytes in a DEPTH-entry FIFO and presents them to the CPU/MMIO side over valid/ready.
//  - Raises an interrupt on a fill level or on line idle, so software need not poll per byte.

---
 rtl/uart_rx_fifo_if.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 tb/tb_uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receive buffer and its neighbours: the UART data
// register on one side, the CPU/MMIO consumer on the other, plus status/irq.
//
// Handshake: out_valid is high whenever the head byte in out_data is
// meaningful; a byte is transferred on a rising clk edge where
// out_valid && out_ready are both high (and no flush is requested).
// out_valid never depends on out_ready, and out_data is stable while
// out_valid is high and no transfer occurs. On the UART side, uart_dat_re is
// a single-cycle read strobe: the UART drops its byte at that same edge.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [31:0]      uart_dat_do;
  logic             uart_dat_re;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [LVL_W-1:0] level;
  logic             almost_full;
  logic             idle_timeout;
  logic             irq;

  // Environment side: drives the UART data word, flush and the consumer ready.
  modport master (
    output uart_dat_do,
    output flush,
    output out_ready,
    input  uart_dat_re,
    input  out_valid,
    input  out_data,
    input  level,
    input  almost_full,
    input  idle_timeout,
    input  irq
  );

  // Buffer side: the uart_rx_fifo block itself.
  modport slave (
    input  uart_dat_do,
    input  flush,
    input  out_ready,
    output uart_dat_re,
    output out_valid,
    output out_data,
    output level,
    output almost_full,
    output idle_timeout,
    output irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the simple UART data register. Drains each byte
// the UART holds, keeps up to DEPTH bytes in a first-word-fall-through FIFO,
// and raises irq on a fill level or when the line has gone idle with data
// still waiting.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int IRQ_LEVEL    = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_IRQ  = LVL_W'(IRQ_LEVEL);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  // Storage and state. The array has no reset: out_data is meaningless while
  // the FIFO is empty, so stale bytes are harmless.
  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [IDLE_W-1:0] r_idle_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_idle_hit;
  logic w_unused_bits;

  // Bits 30:8 of the UART data word carry nothing this block needs.
  assign w_unused_bits = ^bus.uart_dat_do[30:8];

  // Occupancy flags and transfer qualifiers. Fullness uses the registered
  // level, so a byte is never accepted at a full edge even if the consumer
  // frees a slot in the same cycle. Flush suppresses both directions so the
  // pending UART byte stays in the UART.
  always_comb begin
    w_full  = (r_level == LVL_FULL);
    w_empty = (r_level == '0);
    w_push  = !reset && !bus.flush && !bus.uart_dat_do[31] && !w_full;
    w_pop   = !w_empty && bus.out_ready && !bus.flush;
  end

  // Byte capture at the write pointer whenever the UART is strobed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.uart_dat_do[7:0];
    end
  end

  // Pointers and level; pointers wrap naturally at DEPTH since it is a power of 2.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Idle counter: counts cycles spent non-empty without any traffic and
  // saturates at IDLE_TIMEOUT so the idle condition stays asserted.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_idle_cnt <= '0;
    end else if (w_empty || w_push || w_pop) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IDLE_MAX) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // Idle detection is disabled entirely when IDLE_TIMEOUT is zero.
  always_comb begin
    w_idle_hit = (IDLE_TIMEOUT != 0) && (r_idle_cnt == IDLE_MAX) && !w_empty;
  end

  // Outputs: status is derived only from registered state, so it changes
  // only at clock edges.
  assign bus.uart_dat_re  = w_push;
  assign bus.out_valid    = !w_empty;
  assign bus.out_data     = r_mem[r_rd_ptr];
  assign bus.level        = r_level;
  assign bus.almost_full  = (r_level >= LVL_IRQ);
  assign bus.idle_timeout = w_idle_hit;
  assign bus.irq          = (r_level >= LVL_IRQ) || w_idle_hit;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a small UART model feeds bytes, a
// scoreboard queue holds the byte order the consumer must see, and a
// monitor pops and compares on every accepted transfer.
module tb_uart_rx_fifo;

  localparam int DEPTH        = 16;
  localparam int IRQ_LEVEL    = 8;
  localparam int IDLE_TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  logic       re_pre;
  logic [7:0] tmp_b;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) u_if ();

  uart_rx_fifo #(
    .DEPTH       (DEPTH),
    .IRQ_LEVEL   (IRQ_LEVEL),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish in time");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // UART model: shows the front byte of src_q with bit31 clear, else all ones.
  task automatic uart_refresh();
    if (src_q.size() != 0) u_if.uart_dat_do = {24'h0, src_q[0]};
    else                   u_if.uart_dat_do = 32'hFFFF_FFFF;
  endtask

  task automatic put(input logic [7:0] b);
    src_q.push_back(b);
    exp_q.push_back(b);
    uart_refresh();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Called at the negedge; the UART drops its byte at the edge it is strobed.
  task automatic clk_edge();
    re_pre = u_if.uart_dat_re;
    @(posedge clk);
    #1;
    if (re_pre && src_q.size() != 0) tmp_b = src_q.pop_front();
    uart_refresh();
  endtask

  // Scoreboard monitor: compares every byte the consumer accepts.
  always @(negedge clk) begin
    if (reset === 1'b0 && u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1 &&
        u_if.flush === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", u_if.out_data);
      end else begin
        check("pop_data", {24'h0, u_if.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // 1. reset with a byte sitting in the UART
    reset = 1'b1;
    u_if.uart_dat_do = 32'h0000_0041;
    u_if.flush = 1'b0;
    u_if.out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_re",    u_if.uart_dat_re, 0);
      check("rst_valid", u_if.out_valid, 0);
      check("rst_level", u_if.level, 0);
      check("rst_irq",   u_if.irq, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    uart_refresh();

    // 2. single byte
    put(8'h55);
    sample();
    check("t2_re",       u_if.uart_dat_re, 1);
    check("t2_level0",   u_if.level, 0);
    check("t2_valid0",   u_if.out_valid, 0);
    clk_edge();
    u_if.out_ready = 1'b1;
    sample();
    check("t2_re_off",   u_if.uart_dat_re, 0);
    check("t2_valid1",   u_if.out_valid, 1);
    check("t2_data",     u_if.out_data, 8'h55);
    check("t2_level1",   u_if.level, 1);
    clk_edge();
    u_if.out_ready = 1'b0;
    sample();
    check("t2_empty",    u_if.level, 0);
    clk_edge();

    // 3. fill to full, 17th byte held in the UART
    for (int b = 0; b < 16; b++) put(8'(b));
    put(8'hAA);
    for (int k = 0; k < 16; k++) begin
      sample();
      check("t3_fill_level", u_if.level, 32'(k));
      check("t3_fill_re",    u_if.uart_dat_re, 1);
      check("t3_fill_af",    u_if.almost_full, (k >= IRQ_LEVEL) ? 1 : 0);
      clk_edge();
    end
    for (int k = 0; k < 2; k++) begin
      sample();
      check("t3_full_level", u_if.level, 16);
      check("t3_full_re",    u_if.uart_dat_re, 0);
      check("t3_full_irq",   u_if.irq, 1);
      check("t3_full_head",  u_if.out_data, 8'h00);
      clk_edge();
    end
    u_if.out_ready = 1'b1;
    sample();
    check("t3_pop_no_push", u_if.uart_dat_re, 0);
    clk_edge();
    u_if.out_ready = 1'b0;
    sample();
    check("t3_after_pop_level", u_if.level, 15);
    check("t3_after_pop_re",    u_if.uart_dat_re, 1);
    clk_edge();
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample();
      check("t3_drain_level", u_if.level, 32'(16 - i));
      check("t3_drain_af",    u_if.almost_full, ((16 - i) >= IRQ_LEVEL) ? 1 : 0);
      clk_edge();
    end
    u_if.out_ready = 1'b0;
    sample();
    check("t3_empty_level", u_if.level, 0);
    check("t3_empty_valid", u_if.out_valid, 0);
    clk_edge();

    // 4. simultaneous push and pop at level 5
    for (int b = 0; b < 5; b++) put(8'h10 + 8'(b));
    for (int k = 0; k < 5; k++) begin
      sample();
      check("t4_fill_level", u_if.level, 32'(k));
      clk_edge();
    end
    put(8'h20);
    u_if.out_ready = 1'b1;
    sample();
    check("t4_both_re",    u_if.uart_dat_re, 1);
    check("t4_both_level", u_if.level, 5);
    check("t4_both_head",  u_if.out_data, 8'h10);
    clk_edge();
    sample();
    check("t4_same_level", u_if.level, 5);
    check("t4_new_head",   u_if.out_data, 8'h11);
    clk_edge();
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t4_drain_level", u_if.level, 32'(4 - i));
      clk_edge();
    end
    u_if.out_ready = 1'b0;
    sample();
    check("t4_empty_level", u_if.level, 0);
    clk_edge();

    // 5. idle timeout with one byte parked
    put(8'h77);
    sample();
    check("t5_re", u_if.uart_dat_re, 1);
    clk_edge();
    for (int j = 0; j < 6; j++) begin
      if (j == 5) u_if.out_ready = 1'b1;
      sample();
      check("t5_idle", u_if.idle_timeout, (j >= 4) ? 1 : 0);
      check("t5_irq",  u_if.irq, (j >= 4) ? 1 : 0);
      clk_edge();
    end
    u_if.out_ready = 1'b0;
    sample();
    check("t5_clr_irq",   u_if.irq, 0);
    check("t5_clr_idle",  u_if.idle_timeout, 0);
    check("t5_clr_level", u_if.level, 0);
    clk_edge();

    // 6. flush at level 3 with a byte waiting in the UART
    for (int b = 0; b < 3; b++) put(8'h31 + 8'(b));
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t6_fill_level", u_if.level, 32'(k));
      clk_edge();
    end
    put(8'h3F);
    u_if.flush = 1'b1;
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tmp_b = exp_q.pop_front();
    sample();
    check("t6_flush_re",    u_if.uart_dat_re, 0);
    check("t6_flush_level", u_if.level, 3);
    clk_edge();
    u_if.flush = 1'b0;
    u_if.out_ready = 1'b0;
    sample();
    check("t6_post_level", u_if.level, 0);
    check("t6_post_valid", u_if.out_valid, 0);
    check("t6_post_re",    u_if.uart_dat_re, 1);
    check("t6_post_irq",   u_if.irq, 0);
    clk_edge();
    u_if.out_ready = 1'b1;
    sample();
    check("t6_refill_level", u_if.level, 1);
    check("t6_refill_head",  u_if.out_data, 8'h3F);
    clk_edge();
    u_if.out_ready = 1'b0;
    sample();
    check("t6_final_level", u_if.level, 0);
    clk_edge();

    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("src_q_empty", 32'(src_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
